// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: ROM address/data plus the IF->decode valid/ready handshake.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] instruction_memory_address;
  logic [31:0]       instruction_memory_data;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instruction;
  logic [31:0]       if_pc;

  modport master (
    output instruction_memory_address,
    input  instruction_memory_data,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc
  );

  modport slave (
    input  instruction_memory_address,
    output instruction_memory_data,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, reads the combinational ROM and hands one
// registered word per cycle to decode; redirects flush the held word.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  instruction_fetch_unit_if.master fbus,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] count_q, count_d;

  logic xfer;
  logic load;
  logic unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign xfer = valid_q && fbus.if_ready;
  assign load = ((state_q == FETCH) || (state_q == HOLD))
             && fetch_enable
             && (!valid_q || fbus.if_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = fetch_enable ? FETCH : IDLE;
    end else begin
      if (xfer) count_d = count_q + 32'd1;
      if (load) begin
        instr_d = fbus.instruction_memory_data;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end else if (xfer) begin
        valid_d = 1'b0;
      end
      // HOLD means "word presented but not taken"; pc stays frozen
      unique case (state_q)
        IDLE: begin
          if (fetch_enable) state_d = FETCH;
        end
        FETCH, HOLD: begin
          if (!fetch_enable) state_d = DRAIN;
          else if (!load)    state_d = HOLD;
          else               state_d = FETCH;
        end
        DRAIN: begin
          if (!valid_q || fbus.if_ready) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      valid_q <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      count_q <= count_d;
    end
  end

  assign fbus.instruction_memory_address = pc_q[ADDR_W+1:2];
  assign fbus.if_valid       = valid_q;
  assign fbus.if_instruction = instr_q;
  assign fbus.if_pc          = ipc_q;
  assign fetch_count         = count_q;

endmodule
